// File: rtl/ram_rd_chk_pkg.sv
// Shared constants and types for the RAM read-back checker.
// Geometry, FSM encoding and counter widths.
package ram_rd_chk_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;
  localparam int ERR_CNT_W  = 8;
  localparam int PASS_CNT_W = 16;
  localparam int LED_CNT_W  = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

endpackage

// File: rtl/ram_rd_chk_lat_dly.sv
// Fixed-depth register pipeline with synchronous clear.
// Realigns the RAM read strobe/address to the read latency.
module lat_dly #(
  parameter int W = 6,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [N];

  // Shift the tap down the pipe; clear drops anything in flight.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < N; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/ram_rd_chk.sv
// Read-back checker for the single-port RAM test path.
// Compares returned bytes against the write pattern and blinks an LED on error.
module ram_rd_chk
  import ram_rd_chk_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int RD_LATENCY  = 1,
  parameter int DATA_OFFSET = 0,
  parameter int LED_W       = LED_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ram_rd_en,
  input  logic [ADDR_W-1:0]    ram_addr,
  input  logic [DATA_W-1:0]    ram_rd_data,
  output logic                 chk_done,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [PASS_CNT_W-1:0] pass_cnt,
  output logic                 led
);

  logic [ADDR_W:0]   w_dly;
  logic              w_vld_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [DATA_W-1:0] w_exp;
  logic              w_cmp;
  logic              w_mis;
  logic              w_seq_err;
  logic              w_done;
  chk_state_e        w_state_nxt;

  chk_state_e          r_state;
  logic [ADDR_W-1:0]   r_prev_addr;
  logic                r_err_flag;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [ADDR_W-1:0]   r_first_err;
  logic                r_done;
  logic [PASS_CNT_W-1:0] r_pass_cnt;
  logic [LED_W-1:0]    r_blink;
  logic                r_led;

  lat_dly #(
    .W (ADDR_W + 1),
    .N (RD_LATENCY)
  ) u_dly (
    .clk   (clk),
    .i_clr (rst),
    .i_d   ({ram_rd_en, ram_addr}),
    .o_q   (w_dly)
  );

  assign w_vld_d    = w_dly[ADDR_W];
  assign w_addr_d   = w_dly[ADDR_W-1:0];
  assign w_addr_inc = r_prev_addr + ADDR_W'(1);
  assign w_exp      = DATA_W'(32'(w_addr_d) + 32'(DATA_OFFSET));
  assign w_mis      = w_cmp && (ram_rd_data != w_exp);

  // Pass sequencing: decide whether this read is compared,
  // breaks the sequence, or completes the pass.
  always_comb begin
    w_state_nxt = r_state;
    w_cmp       = 1'b0;
    w_seq_err   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_vld_d) begin
          if (w_addr_d == w_addr_inc) begin
            w_cmp = 1'b1;
            if (&w_addr_d) begin
              w_done      = 1'b1;
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_seq_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a fresh start at address 0.
        w_state_nxt = ST_IDLE;
        if (w_vld_d) begin
          w_cmp = 1'b1;
          if (w_addr_d == '0)
            w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // State register and the last compared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prev_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmp)
        r_prev_addr <= w_addr_d;
    end
  end

  // Sticky error status, saturating count, first failing address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      if (w_mis) begin
        if (r_err_cnt != '1)
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        if (!r_err_flag)
          r_first_err <= w_addr_d;
      end
      if (w_mis || w_seq_err)
        r_err_flag <= 1'b1;
    end
  end

  // Pass completion pulse and wrapping pass counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_pass_cnt <= '0;
    end else begin
      r_done <= w_done;
      if (w_done)
        r_pass_cnt <= r_pass_cnt + PASS_CNT_W'(1);
    end
  end

  // LED: steady on while clean, blinks once an error is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= '0;
      r_led   <= 1'b1;
    end else if (r_err_flag) begin
      r_blink <= r_blink + LED_W'(1);
      if (&r_blink)
        r_led <= ~r_led;
    end
  end

  assign chk_done       = r_done;
  assign err_flag       = r_err_flag;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
  assign pass_cnt       = r_pass_cnt;
  assign led            = r_led;

endmodule

// File: tb/tb_ram_rd_chk.sv
// Scoreboard bench for ram_rd_chk: two instances (latency 1 / latency 2).
// Pass records are queued at stimulus time and popped on chk_done.
module tb_ram_rd_chk;
  import ram_rd_chk_pkg::*;

  localparam int LW = 4;

  typedef struct {
    logic [15:0] pass;
    logic        flag;
    logic [7:0]  cnt;
    logic [4:0]  fea;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_en = 1'b0;
  logic [4:0] a_addr = '0;
  logic [7:0] a_dat = '0, a_q = '0;
  logic       a_done, a_flag, a_led;
  logic [7:0] a_cnt;
  logic [4:0] a_fea;
  logic [15:0] a_pass;

  logic       b_rst = 1'b1, b_en = 1'b0;
  logic [4:0] b_addr = '0;
  logic [7:0] b_dat = '0, b_q1 = '0, b_q = '0;
  logic       b_done, b_flag, b_led;
  logic [7:0] b_cnt;
  logic [4:0] b_fea;
  logic [15:0] b_pass;

  ram_rd_chk #(
    .RD_LATENCY(1), .DATA_OFFSET(0), .LED_W(LW)
  ) u_a (
    .clk(clk), .rst(a_rst), .ram_rd_en(a_en),
    .ram_addr(a_addr), .ram_rd_data(a_q),
    .chk_done(a_done), .err_flag(a_flag), .err_cnt(a_cnt),
    .first_err_addr(a_fea), .pass_cnt(a_pass), .led(a_led)
  );

  ram_rd_chk #(
    .RD_LATENCY(2), .DATA_OFFSET(16), .LED_W(LW)
  ) u_b (
    .clk(clk), .rst(b_rst), .ram_rd_en(b_en),
    .ram_addr(b_addr), .ram_rd_data(b_q),
    .chk_done(b_done), .err_flag(b_flag), .err_cnt(b_cnt),
    .first_err_addr(b_fea), .pass_cnt(b_pass), .led(b_led)
  );

  // RAM models: return the byte presented with the read.
  always @(posedge clk) if (a_en) a_q <= a_dat;
  always @(posedge clk) begin
    if (b_en) b_q1 <= b_dat;
    b_q <= b_q1;
  end

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int n_chk = 0, n_err = 0;
  int a_ndone = 0, b_ndone = 0;

  function automatic exp_t mk(int p, bit f, int c, int fa);
    exp_t e;
    e.pass = 16'(p); e.flag = f;
    e.cnt = 8'(c); e.fea = 5'(fa);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_done) begin
      a_ndone++;
      if (qa.size() == 0) begin
        chk("a unexpected chk_done", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a pass_cnt", 32'(a_pass), 32'(ea.pass));
        chk("a err_flag", 32'(a_flag), 32'(ea.flag));
        chk("a err_cnt", 32'(a_cnt), 32'(ea.cnt));
        chk("a first_err_addr", 32'(a_fea), 32'(ea.fea));
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) begin
      b_ndone++;
      if (qb.size() == 0) begin
        chk("b unexpected chk_done", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b pass_cnt", 32'(b_pass), 32'(eb.pass));
        chk("b err_flag", 32'(b_flag), 32'(eb.flag));
        chk("b err_cnt", 32'(b_cnt), 32'(eb.cnt));
        chk("b first_err_addr", 32'(b_fea), 32'(eb.fea));
      end
    end
  end

  task automatic a_rd(input logic [4:0] ad, input logic [7:0] d);
    @(negedge clk);
    a_en = 1'b1; a_addr = ad; a_dat = d;
  endtask

  task automatic b_rd(input logic [4:0] ad, input logic [7:0] d);
    @(negedge clk);
    b_en = 1'b1; b_addr = ad; b_dat = d;
  endtask

  task automatic a_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_en = 1'b0;
    end
  endtask

  task automatic b_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      b_en = 1'b0;
    end
  endtask

  task automatic a_full(input int bad, input bit inv);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] d;
      d = inv ? ~8'(i) : 8'(i);
      if (i == bad) d = 8'hFF;
      a_rd(5'(i), d);
    end
  endtask

  task automatic a_drain(input string nm);
    bit ok;
    ok = 1'b0;
    a_idle(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (qa.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic b_drain(input string nm);
    bit ok;
    ok = 1'b0;
    b_idle(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (qb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic a_chk_rst(input string nm);
    chk({nm, " done"}, 32'(a_done), 32'd0);
    chk({nm, " flag"}, 32'(a_flag), 32'd0);
    chk({nm, " cnt"}, 32'(a_cnt), 32'd0);
    chk({nm, " fea"}, 32'(a_fea), 32'd0);
    chk({nm, " pass"}, 32'(a_pass), 32'd0);
    chk({nm, " led"}, 32'(a_led), 32'd1);
  endtask

  task automatic a_reset();
    @(negedge clk);
    a_rst = 1'b1; a_en = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
  endtask

  initial begin
    int snap;
    bit tog;
    logic l0;

    // Power-on reset of both instances.
    repeat (2) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    a_chk_rst("por a");
    chk("por b flag", 32'(b_flag), 32'd0);
    chk("por b pass", 32'(b_pass), 32'd0);
    chk("por b led", 32'(b_led), 32'd1);

    // Clean pass.
    qa.push_back(mk(1, 0, 0, 0));
    a_full(-1, 0);
    a_drain("t1 drain");
    chk("t1 led", 32'(a_led), 32'd1);
    chk("t1 flag", 32'(a_flag), 32'd0);

    // Single corruption at address 5.
    a_reset();
    a_chk_rst("t2 rst");
    qa.push_back(mk(1, 1, 1, 5));
    a_full(5, 0);
    a_drain("t2 drain");
    l0 = a_led; tog = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_led != l0) begin
        tog = 1'b1;
        break;
      end
    end
    chk("t2 led toggles", 32'(tog), 32'd1);

    // Every byte wrong for ten back-to-back passes.
    a_reset();
    for (int p = 1; p <= 10; p++) begin
      qa.push_back(mk(p, 1, (32 * p > 255) ? 255 : 32 * p, 0));
      a_full(-1, 1);
    end
    a_drain("t3 drain");
    chk("t3 cnt sat", 32'(a_cnt), 32'd255);

    // Sequence break 0,1,2,7.
    a_reset();
    snap = a_ndone;
    a_rd(5'd0, 8'd0); a_rd(5'd1, 8'd1);
    a_rd(5'd2, 8'd2); a_rd(5'd7, 8'd7);
    a_idle(5);
    chk("t4 flag", 32'(a_flag), 32'd1);
    chk("t4 cnt", 32'(a_cnt), 32'd0);
    chk("t4 pass", 32'(a_pass), 32'd0);
    chk("t4 state", 32'(u_a.r_state), 32'(ST_IDLE));
    chk("t4 no done", 32'(a_ndone), 32'(snap));
    qa.push_back(mk(1, 1, 0, 0));
    a_full(-1, 0);
    a_drain("t4 drain");

    // Latency 2, offset 0x10, reads with gaps.
    @(negedge clk); b_rst = 1'b1;
    @(negedge clk); b_rst = 1'b0;
    chk("t5 rst pass", 32'(b_pass), 32'd0);
    qb.push_back(mk(1, 0, 0, 0));
    for (int i = 0; i < 32; i++) begin
      b_rd(5'(i), 8'(i + 16));
      if (i % 3 == 0) b_idle(1);
      if (i == 20) b_idle(3);
    end
    b_drain("t5 drain");
    chk("t5 flag", 32'(b_flag), 32'd0);
    chk("t5 done cnt", 32'(b_ndone), 32'd1);

    // Reset right after address 12, with an error already latched.
    a_reset();
    for (int i = 0; i <= 12; i++)
      a_rd(5'(i), (i == 3) ? 8'hFF : 8'(i));
    @(negedge clk);
    chk("t6 pre flag", 32'(a_flag), 32'd1);
    a_rst = 1'b1; a_en = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    a_chk_rst("t6 rst");
    qa.push_back(mk(1, 0, 0, 0));
    a_full(-1, 0);
    a_drain("t6 drain");
    chk("t6 flag", 32'(a_flag), 32'd0);

    chk("a total done", 32'(a_ndone), 32'd14);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_rd_chk.md
Name: ram_rd_chk

Overview:
- Downstream checker for the 32x8 single-port RAM test path.
- Taps the RAM read strobe, address and read data, realigns strobe/address to the RAM read latency, and compares each returned byte against the known write pattern.
- Reports pass completion, sticky error status, error count and first failing address.
- Drives a board LED, giving the RAM experiment a visible pass/fail result.

Parameters:
- ADDR_W, 5, RAM address width; one pass covers 2**ADDR_W locations.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, clocks from the ram_rd_en/ram_addr sample edge to valid ram_rd_data; legal range 1..3.
- DATA_OFFSET, 0, expected data = (addr + DATA_OFFSET) mod 2**DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ram_rd_en  in  1  RAM read enable, same signal driven to the RAM
- ram_addr  in  ADDR_W  RAM read/write address
- ram_rd_data  in  DATA_W  RAM q output
- chk_done  out  1  one-cycle pulse when the read of address 2**ADDR_W-1 has been checked
- err_flag  out  1  sticky, set on first mismatch or sequence error
- err_cnt  out  8  mismatch count, saturates at 255
- first_err_addr  out  ADDR_W  address of the first mismatch
- pass_cnt  out  16  completed passes, wraps 65535->0
- led  out  1  steady high = no error; toggles every 2**22 clocks once err_flag=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0 except led=1.
  - Delay pipeline and state clear; state=IDLE.
  - Reset mid-pass discards in-flight reads.
- Alignment:
  - ram_rd_en and ram_addr pass through a RD_LATENCY-deep shift register, giving vld_d and addr_d.
  - A compare happens in the cycle where vld_d=1, using ram_rd_data.
  - ram_rd_data is ignored whenever vld_d=0.
- Compare:
  - exp = addr_d + DATA_OFFSET, truncated to DATA_W.
  - Mismatch when ram_rd_data != exp.
  - On mismatch:
    - err_cnt increments, saturating at 255.
    - err_flag is set.
    - first_err_addr loads addr_d only if err_flag was 0 before this cycle.
- FSM states IDLE, RUN, DONE:
  - IDLE: on vld_d=1 with addr_d=0, go to RUN and compare that read. A vld_d with addr_d!=0 is compared but stays in IDLE; this tolerates a partial pass after reset.
  - RUN: every vld_d must carry addr_d = prev_addr+1. Otherwise set err_flag (sequence error), leave err_cnt unchanged, and return to IDLE. Gaps with vld_d=0 are allowed.
  - RUN with vld_d=1 and addr_d = 2**ADDR_W-1 in sequence: compare, pulse chk_done next cycle, increment pass_cnt, go to DONE.
  - DONE: one cycle, then IDLE. A vld_d with addr_d=0 in this cycle is treated as an IDLE start, so back-to-back passes are allowed.
- Simultaneous mismatch and last address:
  - Both the error update and chk_done/pass_cnt happen.
  - A pass with an error still counts.
- led:
  - A 22-bit free-running counter runs only while err_flag=1.
  - led toggles on counter wrap.
- ram_wr_en is not observed. Write/read interleaving is the responsibility of the upstream sequencer.

Decomposition:
- Shared package:
  - RAM geometry constants: ADDR_W=5, DATA_W=8, depth 32.
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Error-count width.
  - LED blink counter width.
- One natural sub-module, lat_dly: a parameterised RD_LATENCY-stage register pipeline with synchronous active-high clear, carrying {vld, addr}.

Test Plan:
- Clean pass:
  - Stimulus: RD_LATENCY=1; read addresses 0..31 back-to-back, returning data = addr one cycle later.
  - Required: chk_done pulses once, pass_cnt=1, err_flag=0, err_cnt=0, led=1.
- Single corruption:
  - Stimulus: as above, but address 5 returns 8'hFF.
  - Required: err_flag=1, err_cnt=1, first_err_addr=5, pass_cnt=1, led starts toggling.
- Saturation and first address:
  - Stimulus: 10 passes where every byte mismatches (320 errors).
  - Required: err_cnt=255, first_err_addr=0, pass_cnt=10.
- Sequence break:
  - Stimulus: read 0,1,2,7.
  - Required: err_flag=1, err_cnt=0, no chk_done, state back in IDLE. A following clean 0..31 then gives pass_cnt=1.
- Latency and gaps:
  - Stimulus: RD_LATENCY=2, DATA_OFFSET=8'h10; reads interleaved with idle cycles; data = addr+16 two cycles later.
  - Required: no error, one chk_done.
- Reset mid-pass:
  - Stimulus: rst=1 for one cycle after address 12 is read.
  - Required: all outputs 0 (led=1) next cycle. A subsequent full pass gives pass_cnt=1 and no error.
